// File: rtl/serial_regfile.sv
// serial_regfile: digit-serial register file with a built-in beat sequencer.
// A single start pulse latches the read/write selections and the sequencer
// then walks every digit position once. Each beat streams one digit of rs1
// and one of rs2 and optionally commits one digit of rd.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; digit outputs forced to zero
// RUN   | streaming beats; cnt_q is the logical beat, hold_i freezes it
module serial_regfile #(
    parameter int XLEN      = 32,
    parameter int DIGIT     = 1,
    parameter int NREGS     = 32,
    parameter int ZERO_REG  = 1,
    parameter int MSB_FIRST = 0,
    localparam int BEATS    = XLEN / DIGIT,
    localparam int RSEL     = $clog2(NREGS),
    localparam int IW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [RSEL-1:0]  rs1_sel_i,
    input  logic [RSEL-1:0]  rs2_sel_i,
    input  logic [RSEL-1:0]  rd_sel_i,
    input  logic             rd_we_i,
    input  logic             hold_i,
    input  logic [DIGIT-1:0] rd_digit_i,
    output logic [DIGIT-1:0] rs1_digit_o,
    output logic [DIGIT-1:0] rs2_digit_o,
    output logic [IW-1:0]    digit_idx_o,
    output logic             busy_o,
    output logic             last_o,
    output logic             done_o
);

    localparam bit          ZR       = (ZERO_REG != 0);
    localparam bit          MSB      = (MSB_FIRST != 0);
    localparam logic [IW-1:0] LAST_CNT = IW'(BEATS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   cnt_q;
    logic [RSEL-1:0] rs1_q;
    logic [RSEL-1:0] rs2_q;
    logic [RSEL-1:0] rd_q;
    logic            we_q;
    logic            busy_q;
    logic            done_q;

    // Storage is organised per digit so a beat addresses one element directly.
    // It is deliberately outside the reset domain: rst only aborts transfers.
    logic [DIGIT-1:0] mem_q [NREGS][BEATS] = '{default: '0};

    logic [IW-1:0] idx_d;
    logic          wr_en_d;
    logic          rs1_zero_d;
    logic          rs2_zero_d;

    // Sequencer: accept start only when idle, advance one beat per unheld cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rs1_q   <= rs1_sel_i;
                        rs2_q   <= rs2_sel_i;
                        rd_q    <= rd_sel_i;
                        we_q    <= rd_we_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold_i) begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Physical digit position for the current beat and the write qualifier.
    // A reset edge must not commit the beat that was on the bus.
    always_comb begin
        idx_d      = MSB ? (LAST_CNT - cnt_q) : cnt_q;
        rs1_zero_d = ZR && (rs1_q == '0);
        rs2_zero_d = ZR && (rs2_q == '0);
        wr_en_d    = !rst_i && busy_q && !hold_i && we_q && !(ZR && (rd_q == '0));
    end

    // Digit commit; reads in the same beat still see the old digit.
    always_ff @(posedge clk_i) begin
        if (wr_en_d) begin
            mem_q[rd_q][idx_d] <= rd_digit_i;
        end
    end

    // Combinational read ports and status, all quiet while idle.
    always_comb begin
        rs1_digit_o = '0;
        rs2_digit_o = '0;
        digit_idx_o = '0;
        if (busy_q) begin
            digit_idx_o = idx_d;
            if (!rs1_zero_d) begin
                rs1_digit_o = mem_q[rs1_q][idx_d];
            end
            if (!rs2_zero_d) begin
                rs2_digit_o = mem_q[rs2_q][idx_d];
            end
        end
        busy_o = busy_q;
        last_o = busy_q && (cnt_q == LAST_CNT);
        done_o = done_q;
    end

endmodule

// File: tb/tb_serial_regfile.sv
// Bench for serial_regfile: a 1-bit LSB-first build with a zero register and a
// 4-bit MSB-first build without one, checked against whole-register models.
module tb_serial_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic [4:0] rs1_sel;
    logic [4:0] rs2_sel;
    logic [4:0] rd_sel;
    logic       we;
    logic       hold;
    logic       rd_digit_a;
    logic [3:0] rd_digit_b;

    logic       rs1_a, rs2_a, busy_a, last_a, done_a;
    logic [4:0] idx_a;
    logic [3:0] rs1_b, rs2_b;
    logic [2:0] idx_b;
    logic       busy_b, last_b, done_b;

    logic [31:0] ref_a [32];
    logic [31:0] ref_b [32];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_regfile #(.XLEN(32), .DIGIT(1), .NREGS(32), .ZERO_REG(1), .MSB_FIRST(0)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .rs1_sel_i(rs1_sel), .rs2_sel_i(rs2_sel), .rd_sel_i(rd_sel), .rd_we_i(we),
        .hold_i(hold), .rd_digit_i(rd_digit_a),
        .rs1_digit_o(rs1_a), .rs2_digit_o(rs2_a), .digit_idx_o(idx_a),
        .busy_o(busy_a), .last_o(last_a), .done_o(done_a)
    );

    serial_regfile #(.XLEN(32), .DIGIT(4), .NREGS(32), .ZERO_REG(0), .MSB_FIRST(1)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .rs1_sel_i(rs1_sel), .rs2_sel_i(rs2_sel), .rd_sel_i(rd_sel), .rd_we_i(we),
        .hold_i(hold), .rd_digit_i(rd_digit_b),
        .rs1_digit_o(rs1_b), .rs2_digit_o(rs2_b), .digit_idx_o(idx_b),
        .busy_o(busy_b), .last_o(last_b), .done_o(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit use_b, output logic [31:0] o_busy, output logic [31:0] o_idx,
                          output logic [31:0] o_rs1, output logic [31:0] o_rs2,
                          output logic [31:0] o_last, output logic [31:0] o_done);
        o_busy = use_b ? 32'(busy_b) : 32'(busy_a);
        o_idx  = use_b ? 32'(idx_b)  : 32'(idx_a);
        o_rs1  = use_b ? 32'(rs1_b)  : 32'(rs1_a);
        o_rs2  = use_b ? 32'(rs2_b)  : 32'(rs2_a);
        o_last = use_b ? 32'(last_b) : 32'(last_a);
        o_done = use_b ? 32'(done_b) : 32'(done_a);
    endtask

    task automatic check_idle(input bit use_b, input string tag);
        logic [31:0] o_busy, o_idx, o_rs1, o_rs2, o_last, o_done;
        sample(use_b, o_busy, o_idx, o_rs1, o_rs2, o_last, o_done);
        chk({tag, "_busy"}, o_busy, 32'd0);
        chk({tag, "_idx"},  o_idx,  32'd0);
        chk({tag, "_rs1"},  o_rs1,  32'd0);
        chk({tag, "_rs2"},  o_rs2,  32'd0);
        chk({tag, "_last"}, o_last, 32'd0);
        chk({tag, "_done"}, o_done, 32'd0);
    endtask

    // One full transfer, entered and left at a falling edge. Expected read
    // digits come from the register values as they stood when start was taken.
    task automatic xfer(input bit use_b, input int rs1, input int rs2, input int rd, input bit wen,
                        input logic [31:0] wdata, input int hold_beat, input int hold_n,
                        input bit rand_hold, input int ign_beat, input int rst_beat);
        int beats, dig, beat, cyc, held, k;
        bit zr, h;
        logic [31:0] dmask, old1, old2, m, sh;
        logic [31:0] o_busy, o_idx, o_rs1, o_rs2, o_last, o_done;
        beats = use_b ? 8 : 32;
        dig   = use_b ? 4 : 1;
        dmask = use_b ? 32'hF : 32'h1;
        zr    = !use_b;
        old1  = use_b ? ref_b[rs1] : ref_a[rs1];
        old2  = use_b ? ref_b[rs2] : ref_a[rs2];
        if (zr && rs1 == 0) old1 = '0;
        if (zr && rs2 == 0) old2 = '0;
        beat = 0; cyc = 0; held = 0;

        rs1_sel = 5'(rs1); rs2_sel = 5'(rs2); rd_sel = 5'(rd); we = wen;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;

        while (beat < beats && cyc < 400) begin
            k = use_b ? (beats - 1 - beat) : beat;
            sample(use_b, o_busy, o_idx, o_rs1, o_rs2, o_last, o_done);
            chk("beat_busy", o_busy, 32'd1);
            chk("beat_idx",  o_idx,  32'(k));
            chk("beat_rs1",  o_rs1,  (old1 >> (k * dig)) & dmask);
            chk("beat_rs2",  o_rs2,  (old2 >> (k * dig)) & dmask);
            chk("beat_last", o_last, {31'b0, beat == beats - 1});
            chk("beat_done", o_done, 32'd0);

            sh = wdata >> (k * dig);
            rd_digit_a = sh[0];
            rd_digit_b = sh[3:0];
            h = (beat == hold_beat && held < hold_n) || (rand_hold && $urandom_range(0, 3) == 0);
            hold = h;
            if (beat == ign_beat) begin
                rs1_sel = 5'd9;
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end

            if (beat == rst_beat) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; hold = 1'b0; start_a = 1'b0; start_b = 1'b0;
                rs1_sel = 5'(rs1);
                sample(use_b, o_busy, o_idx, o_rs1, o_rs2, o_last, o_done);
                chk("rst_busy", o_busy, 32'd0);
                chk("rst_done", o_done, 32'd0);
                @(negedge clk);
                sample(use_b, o_busy, o_idx, o_rs1, o_rs2, o_last, o_done);
                chk("rst_done2", o_done, 32'd0);
                chk("rst_busy2", o_busy, 32'd0);
                return;
            end

            @(negedge clk);
            cyc++;
            start_a = 1'b0; start_b = 1'b0;
            rs1_sel = 5'(rs1);
            if (h) begin
                held++;
            end else begin
                if (wen && !(zr && rd == 0)) begin
                    m = dmask << (k * dig);
                    if (use_b) ref_b[rd] = (ref_b[rd] & ~m) | (wdata & m);
                    else       ref_a[rd] = (ref_a[rd] & ~m) | (wdata & m);
                end
                beat++;
            end
        end
        hold = 1'b0;
        chk("no_timeout", 32'(beat), 32'(beats));
        chk("latency", 32'(cyc + 1), 32'(beats + 1 + held));
        sample(use_b, o_busy, o_idx, o_rs1, o_rs2, o_last, o_done);
        chk("end_done", o_done, 32'd1);
        chk("end_busy", o_busy, 32'd0);
        chk("end_last", o_last, 32'd0);
        chk("end_rs1",  o_rs1,  32'd0);
        chk("end_idx",  o_idx,  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_a[i] = '0;
            ref_b[i] = '0;
        end
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; we = 1'b0; hold = 1'b0;
        rs1_sel = '0; rs2_sel = '0; rd_sel = '0; rd_digit_a = 1'b0; rd_digit_b = '0;
        repeat (3) @(negedge clk);
        check_idle(1'b0, "rst_a");
        check_idle(1'b1, "rst_b");
        rst = 1'b0;
        @(negedge clk);
        check_idle(1'b0, "post_rst_a");

        // 0xDEADBEEF into x5, then stream it back on both ports.
        xfer(1'b0, 1, 2, 5, 1'b1, 32'hDEADBEEF, -1, 0, 1'b0, -1, -1);
        xfer(1'b0, 5, 5, 1, 1'b0, 32'h0, -1, 0, 1'b0, -1, -1);

        // Writes to x0 are dropped and x0 reads as zero.
        xfer(1'b0, 5, 1, 0, 1'b1, 32'hFFFFFFFF, -1, 0, 1'b0, -1, -1);
        xfer(1'b0, 0, 0, 1, 1'b0, 32'h0, -1, 0, 1'b0, -1, -1);

        // Same register read and written: the stream shows the old value.
        xfer(1'b0, 1, 2, 7, 1'b1, 32'h0000FFFF, -1, 0, 1'b0, -1, -1);
        xfer(1'b0, 7, 0, 7, 1'b1, 32'h12345678, -1, 0, 1'b0, -1, -1);
        xfer(1'b0, 7, 5, 1, 1'b0, 32'h0, -1, 0, 1'b0, -1, -1);

        // Hold on beat 3 for three cycles, stray start with rs1=9 at beat 10.
        xfer(1'b0, 1, 1, 9, 1'b1, $urandom, -1, 0, 1'b0, -1, -1);
        xfer(1'b0, 5, 7, 11, 1'b1, $urandom, 3, 3, 1'b0, 10, -1);
        xfer(1'b0, 11, 9, 1, 1'b0, 32'h0, -1, 0, 1'b0, -1, -1);

        // Reset at beat 10 while overwriting x3 with ones.
        xfer(1'b0, 5, 7, 3, 1'b1, 32'hFFFFFFFF, -1, 0, 1'b0, -1, 10);
        xfer(1'b0, 3, 3, 1, 1'b0, 32'h0, -1, 0, 1'b0, -1, -1);

        // Randomised transfers with random stalls on the 1-bit build.
        for (int t = 0; t < 24; t++) begin
            xfer(1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                 -1, 0, 1'b1, -1, -1);
        end

        // 4-bit MSB-first build, no zero register.
        xfer(1'b1, 1, 2, 0, 1'b1, 32'hFFFFFFFF, -1, 0, 1'b0, -1, -1);
        xfer(1'b1, 0, 0, 1, 1'b0, 32'h0, -1, 0, 1'b0, -1, -1);
        xfer(1'b1, 1, 2, 4, 1'b1, 32'hA5C3E10F, -1, 0, 1'b0, -1, -1);
        xfer(1'b1, 4, 0, 4, 1'b1, 32'h0F1E2D3C, 2, 2, 1'b0, -1, -1);
        xfer(1'b1, 4, 4, 1, 1'b0, 32'h0, -1, 0, 1'b0, -1, -1);
        for (int t = 0; t < 12; t++) begin
            xfer(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                 -1, 0, 1'b1, -1, -1);
        end

        @(negedge clk);
        check_idle(1'b0, "final_a");
        check_idle(1'b1, "final_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
